// File: rtl/multiplication.sv
// Shift-and-add multiplier rebuilding Product = Q*M (+ R when MULT_ADDEND_EN is defined),
// fixed latency start/busy/done handshake with registered outputs.
module multiplication #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   Q,
  input  logic [WIDTH-1:0]   M,
  input  logic [WIDTH-1:0]   R,
  output logic [2*WIDTH-1:0] Product,
  output logic               busy,
  output logic               done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [2*WIDTH-1:0] mcand, mcand_next;
  logic [WIDTH-1:0]   mplier, mplier_next;
  logic [CW-1:0]      cnt, cnt_next;
  logic [2*WIDTH-1:0] product_next;
  logic               busy_next, done_next;
  logic [2*WIDTH-1:0] acc_init;

`ifdef MULT_ADDEND_EN
  assign acc_init = {{WIDTH{1'b0}}, R};
`else
  // R stays on the port for pin compatibility but does not feed the datapath.
  logic unused_r;
  assign unused_r = ^R;
  assign acc_init = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      Product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      acc     <= acc_next;
      mcand   <= mcand_next;
      mplier  <= mplier_next;
      cnt     <= cnt_next;
      Product <= product_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  // busy is kept high on the DONE edge so it covers the done cycle itself.
  always_comb begin
    state_next   = state;
    acc_next     = acc;
    mcand_next   = mcand;
    mplier_next  = mplier;
    cnt_next     = cnt;
    product_next = Product;
    busy_next    = busy;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        busy_next = 1'b0;
        if (start) begin
          state_next  = RUN;
          busy_next   = 1'b1;
          acc_next    = acc_init;
          mcand_next  = {{WIDTH{1'b0}}, M};
          mplier_next = Q;
          cnt_next    = '0;
        end
      end
      RUN: begin
        if (mplier[0]) acc_next = acc + mcand;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        cnt_next    = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) state_next = DONE;
      end
      DONE: begin
        product_next = acc;
        done_next    = 1'b1;
        busy_next    = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multiplication.sv
// Directed bench for multiplication: cycle-level latency model plus literal result checks.
module tb_multiplication;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] Q, M, R;
  logic [7:0] Product;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

`ifdef MULT_ADDEND_EN
  localparam bit ADDEND_EN = 1'b1;
`else
  localparam bit ADDEND_EN = 1'b0;
`endif

  multiplication #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Q(Q), .M(M), .R(R),
    .Product(Product), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: age counts edges since the accepting edge; result shows 5 edges later.
  int  age = 0;
  int  pending = 0;
  int  expProduct = 0;
  bit  expBusy = 1'b0;
  bit  expDone = 1'b0;
  bit  compareOn = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age = 0; expBusy = 1'b0; expDone = 1'b0; expProduct = 0;
    end else begin
      if (age == 0 || age == 6) begin
        if (start) begin
          pending = int'(Q) * int'(M) + (ADDEND_EN ? int'(R) : 0);
          age = 1;
        end else begin
          age = 0;
        end
      end else begin
        age = age + 1;
      end
      expBusy = (age != 0);
      expDone = (age == 6);
      if (age == 6) expProduct = pending;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("model_busy", int'(busy), int'(expBusy));
      checkOutput("model_done", int'(done), int'(expDone));
      checkOutput("model_product", int'(Product), expProduct);
    end
  end

  // Pulse start for one cycle, then wait (bounded) for done and check latency and result.
  task automatic applyStimulus(input logic [3:0] q, input logic [3:0] m, input logic [3:0] r,
                               input int expP, input string name);
    int n;
    Q = q; M = m; R = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_done"}, int'(done), 1);
    checkOutput({name, "_latency"}, n, 5);
    checkOutput({name, "_product"}, int'(Product), expP);
    @(negedge clk);
    checkOutput({name, "_busy_clear"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    int doneCount;
    rst_n = 1'b1; start = 1'b0; Q = '0; M = '0; R = '0;
    #1 rst_n = 1'b0;
    #1 compareOn = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_product", int'(Product), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic products");
    applyStimulus(4'd15, 4'd15, 4'd0, 225, "max_sq");
    applyStimulus(4'd4, 4'd2, 4'd0, 8, "four_two");
    applyStimulus(4'd0, 4'd15, 4'd0, 0, "zero_q");
    applyStimulus(4'd3, 4'd2, 4'd2, ADDEND_EN ? 8 : 6, "addend_small");
    applyStimulus(4'd15, 4'd15, 4'd14, ADDEND_EN ? 239 : 225, "addend_max");

    $display("[TB] start held, operand change mid-run");
    Q = 4'd2; M = 4'd3; R = 4'd0; start = 1'b1;
    repeat (2) @(negedge clk);
    Q = 4'd7;
    n = 2;
    while (!done && n < 20) begin @(negedge clk); n++; end
    checkOutput("held_first_product", int'(Product), 6);
    n = 0;
    @(negedge clk); n++;
    while (!done && n < 20) begin @(negedge clk); n++; end
    start = 1'b0;
    checkOutput("held_spacing", n, 6);
    checkOutput("held_second_product", int'(Product), 21);
    repeat (2) @(negedge clk);
    checkOutput("held_idle", int'(busy), 0);

    $display("[TB] start during run ignored");
    Q = 4'd5; M = 4'd3; R = 4'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    Q = 4'd9; M = 4'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        doneCount++;
        checkOutput("ignored_product", int'(Product), 15);
      end
      @(negedge clk);
    end
    checkOutput("ignored_done_count", doneCount, 1);

    $display("[TB] reset mid-run");
    Q = 4'd6; M = 4'd7; R = 4'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_product", int'(Product), 0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("abort_no_done", doneCount, 0);
    applyStimulus(4'd6, 4'd7, 4'd0, 42, "after_abort");

    repeat (2) @(negedge clk);
    compareOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
